// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - state encoding, instruction classes, special opcodes and default widths
package mcu_pkg;

    localparam int DEF_OPCODE_W    = 5;
    localparam int DEF_ALU_OP_W    = 3;
    localparam int DEF_MEM_TIMEOUT = 15;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR,
        CL_SYSCALL, CL_LUI, CL_LW, CL_SW, CL_EXIT
    } instr_class_t;

    localparam logic [4:0] OP_BEQ     = 5'b00101;
    localparam logic [4:0] OP_BNE     = 5'b01101;
    localparam logic [4:0] OP_J       = 5'b00110;
    localparam logic [4:0] OP_JAL     = 5'b00010;
    localparam logic [4:0] OP_JR      = 5'b01010;
    localparam logic [4:0] OP_SYSCALL = 5'b10110;
    localparam logic [4:0] OP_LUI     = 5'b10101;
    localparam logic [4:0] OP_LW      = 5'b01001;
    localparam logic [4:0] OP_SW      = 5'b00001;
    localparam logic [4:0] OP_EXIT    = 5'b11111;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - opcode/control bundle; mem_ready and mem_timeout exist only with MCU_MEM_HANDSHAKE_EN
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = mcu_pkg::DEF_OPCODE_W,
    parameter int ALU_OP_W = mcu_pkg::DEF_ALU_OP_W
);
    logic [OPCODE_W-1:0] opcode;
    logic                instr_valid;
    logic                pc_write;
    logic                ir_write;
    logic [ALU_OP_W-1:0] alu_op;
    logic                jump;
    logic                branch;
    logic                jump_reg;
    logic                call;
    logic                shift_reg;
    logic                mem_read;
    logic                mem_write;
    logic                alu_src;
    logic                reg_dst;
    logic                reg_write;
    logic                halted;
    logic [2:0]          state;
`ifdef MCU_MEM_HANDSHAKE_EN
    logic                mem_ready;
    logic                mem_timeout;
`endif

    modport master (
        output opcode, instr_valid,
`ifdef MCU_MEM_HANDSHAKE_EN
        output mem_ready,
        input  mem_timeout,
`endif
        input  pc_write, ir_write, alu_op, jump, branch, jump_reg, call, shift_reg,
        input  mem_read, mem_write, alu_src, reg_dst, reg_write, halted, state
    );

    modport slave (
        input  opcode, instr_valid,
`ifdef MCU_MEM_HANDSHAKE_EN
        input  mem_ready,
        output mem_timeout,
`endif
        output pc_write, ir_write, alu_op, jump, branch, jump_reg, call, shift_reg,
        output mem_read, mem_write, alu_src, reg_dst, reg_write, halted, state
    );

endinterface

// File: rtl/mcu_decoder.sv
// rtl/mcu_decoder.sv - combinational map from the latched opcode to instruction class and datapath fields
module mcu_decoder import mcu_pkg::*; #(
    parameter int OPCODE_W = DEF_OPCODE_W,
    parameter int ALU_OP_W = DEF_ALU_OP_W
) (
    input  logic [OPCODE_W-1:0] op,
    output instr_class_t        cls,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_dst,
    output logic                alu_src,
    output logic                shift_reg
);

    always_comb begin
        cls       = CL_ALU;
        alu_op    = op[OPCODE_W-1 -: ALU_OP_W];
        reg_dst   = ~op[0];
        alu_src   = op[0];
        shift_reg = 1'b0;
        // Overrides stay valid in every state the field is shown in, so lw keeps alu_op=0 into MEM and WB
        case (op)
            OPCODE_W'(OP_BEQ): begin
                cls     = CL_BEQ;
                alu_src = 1'b0;
            end
            OPCODE_W'(OP_BNE): begin
                cls     = CL_BNE;
                alu_src = 1'b0;
                alu_op  = ALU_OP_W'(1);
                reg_dst = 1'b1;
            end
            OPCODE_W'(OP_J):   cls = CL_J;
            OPCODE_W'(OP_JAL): cls = CL_JAL;
            OPCODE_W'(OP_JR):  cls = CL_JR;
            OPCODE_W'(OP_SYSCALL): begin
                cls     = CL_SYSCALL;
                reg_dst = 1'b0;
            end
            OPCODE_W'(OP_LUI): begin
                cls       = CL_LUI;
                shift_reg = 1'b1;
            end
            OPCODE_W'(OP_LW): begin
                cls    = CL_LW;
                alu_op = '0;
            end
            OPCODE_W'(OP_SW):   cls = CL_SW;
            OPCODE_W'(OP_EXIT): cls = CL_EXIT;
            default:            cls = CL_ALU;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle FSM with op_q latch; MCU_MEM_HANDSHAKE_EN adds mem_ready wait and timeout to HALT
module multicycle_control_unit import mcu_pkg::*; #(
    parameter int OPCODE_W    = DEF_OPCODE_W,
    parameter int ALU_OP_W    = DEF_ALU_OP_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_control_unit_if.slave bus
);

    if (OPCODE_W < 5 || ALU_OP_W > OPCODE_W - 2 || MEM_TIMEOUT < 1) begin : g_bad_params
        $error("multicycle_control_unit: illegal parameter combination");
    end

    state_t              state_q;
    logic [OPCODE_W-1:0] op_q;
    instr_class_t        cls;
    logic [ALU_OP_W-1:0] dec_alu_op;
    logic                dec_reg_dst;
    logic                dec_alu_src;
    logic                dec_shift_reg;

    mcu_decoder #(.OPCODE_W(OPCODE_W), .ALU_OP_W(ALU_OP_W)) u_decoder (
        .op        (op_q),
        .cls       (cls),
        .alu_op    (dec_alu_op),
        .reg_dst   (dec_reg_dst),
        .alu_src   (dec_alu_src),
        .shift_reg (dec_shift_reg)
    );

`ifdef MCU_MEM_HANDSHAKE_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
`ifdef MCU_MEM_HANDSHAKE_EN
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef MCU_MEM_HANDSHAKE_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                ST_FETCH: begin
                    if (bus.instr_valid) begin
                        op_q    <= bus.opcode;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: state_q <= (cls == CL_EXIT) ? ST_HALT : ST_EXEC;
                ST_EXEC: begin
                    case (cls)
                        CL_BEQ, CL_BNE, CL_J, CL_JR, CL_SYSCALL: state_q <= ST_FETCH;
                        CL_LW, CL_SW:                            state_q <= ST_MEM;
                        default:                                 state_q <= ST_WB;
                    endcase
                end
                ST_MEM: begin
`ifdef MCU_MEM_HANDSHAKE_EN
                    // wait_cnt counts MEM cycles already spent without mem_ready
                    if (bus.mem_ready) begin
                        wait_cnt <= '0;
                        state_q  <= (cls == CL_LW) ? ST_WB : ST_FETCH;
                    end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        wait_cnt  <= '0;
                        timeout_q <= 1'b1;
                        state_q   <= ST_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`else
                    state_q <= (cls == CL_LW) ? ST_WB : ST_FETCH;
`endif
                end
                ST_WB:   state_q <= ST_FETCH;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.pc_write  = 1'b0;
        bus.ir_write  = 1'b0;
        bus.alu_op    = '0;
        bus.jump      = 1'b0;
        bus.branch    = 1'b0;
        bus.jump_reg  = 1'b0;
        bus.call      = 1'b0;
        bus.shift_reg = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.alu_src   = 1'b0;
        bus.reg_dst   = 1'b0;
        bus.reg_write = 1'b0;
        bus.halted    = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    bus.mem_read = 1'b1;
                    bus.ir_write = bus.instr_valid;
                    bus.pc_write = bus.instr_valid;
                end
                ST_EXEC: begin
                    bus.alu_op    = dec_alu_op;
                    bus.reg_dst   = dec_reg_dst;
                    bus.alu_src   = dec_alu_src;
                    bus.shift_reg = dec_shift_reg;
                    case (cls)
                        CL_BEQ, CL_BNE: begin
                            bus.branch   = 1'b1;
                            bus.pc_write = 1'b1;
                        end
                        CL_J, CL_JAL: begin
                            bus.jump     = 1'b1;
                            bus.pc_write = 1'b1;
                        end
                        CL_JR: begin
                            bus.jump_reg = 1'b1;
                            bus.pc_write = 1'b1;
                        end
                        CL_SYSCALL: bus.call = 1'b1;
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    bus.alu_op    = dec_alu_op;
                    bus.reg_dst   = dec_reg_dst;
                    bus.alu_src   = dec_alu_src;
                    bus.mem_read  = (cls == CL_LW);
                    bus.mem_write = (cls == CL_SW);
                end
                ST_WB: begin
                    bus.alu_op    = dec_alu_op;
                    bus.reg_dst   = dec_reg_dst;
                    bus.alu_src   = dec_alu_src;
                    bus.shift_reg = dec_shift_reg;
                    bus.reg_write = 1'b1;
                end
                ST_HALT: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.state = reset ? 3'd0 : state_q;
`ifdef MCU_MEM_HANDSHAKE_EN
    assign bus.mem_timeout = timeout_q & ~reset;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit (handshake cases under MCU_MEM_HANDSHAKE_EN)
module tb_multicycle_control_unit;

    localparam int PCW = 1 << 0, IRW = 1 << 1, JMP = 1 << 2, BRA = 1 << 3, JR = 1 << 4;
    localparam int CAL = 1 << 5, SHF = 1 << 6, MRD = 1 << 7, MWR = 1 << 8, ASRC = 1 << 9;
    localparam int RDST = 1 << 10, RWR = 1 << 11, HLT = 1 << 12, MTO = 1 << 13;
    localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_H = 5;

    typedef struct {
        logic [19:0] v;
        string       name;
    } exp_t;

    bit   clk;
    logic reset = 1'b1;
    exp_t exp_q[$];
    exp_t item;
    logic [19:0] act;
    int   errors = 0;
    int   checks = 0;
`ifdef MCU_MEM_HANDSHAKE_EN
    logic mr_drv = 1'b1;
`endif

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ev(input int st, input int alu, input int fl);
        logic [19:0] r;
        r[19:17] = st[2:0];
        r[16:14] = alu[2:0];
        r[13:0]  = fl[13:0];
        return r;
    endfunction

    task automatic step(input logic rst, input logic iv, input logic [4:0] opc,
                        input string nm, input logic [19:0] e);
        exp_t it;
        reset           = rst;
        bus.instr_valid = iv;
        bus.opcode      = opc;
`ifdef MCU_MEM_HANDSHAKE_EN
        bus.mem_ready   = mr_drv;
`endif
        it.v    = e;
        it.name = nm;
        exp_q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic f_d(input logic [4:0] opc, input string nm);
        step(1'b0, 1'b1, opc, {nm, "_fetch"}, ev(S_F, 0, MRD | IRW | PCW));
        step(1'b0, 1'b0, 5'd0, {nm, "_decode"}, ev(S_D, 0, 0));
    endtask

    task automatic idle(input string nm);
        step(1'b0, 1'b0, 5'd0, nm, ev(S_F, 0, MRD));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            act = {bus.state, bus.alu_op,
`ifdef MCU_MEM_HANDSHAKE_EN
                   bus.mem_timeout,
`else
                   1'b0,
`endif
                   bus.halted, bus.reg_write, bus.reg_dst, bus.alu_src, bus.mem_write,
                   bus.mem_read, bus.shift_reg, bus.call, bus.jump_reg, bus.branch,
                   bus.jump, bus.ir_write, bus.pc_write};
            checks++;
            if (act !== item.v) begin
                errors++;
                $display("FAIL %s: got %05h required %05h", item.name, act, item.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
`ifdef MCU_MEM_HANDSHAKE_EN
        bus.mem_ready   = 1'b1;
`endif
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 5'b00000, "reset0", ev(0, 0, 0));
        step(1'b1, 1'b0, 5'b00000, "reset1", ev(0, 0, 0));
        idle("idle_after_reset");

        f_d(5'b00000, "add");
        step(1'b0, 1'b0, 5'd0, "add_exec", ev(S_E, 0, RDST));
        step(1'b0, 1'b0, 5'd0, "add_wb", ev(S_W, 0, RDST | RWR));
        idle("add_done");

        f_d(5'b01101, "bne");
        step(1'b0, 1'b0, 5'd0, "bne_exec", ev(S_E, 1, BRA | PCW | RDST));
        idle("bne_done");

        f_d(5'b00101, "beq");
        step(1'b0, 1'b0, 5'd0, "beq_exec", ev(S_E, 1, BRA | PCW));
        idle("beq_done");

        f_d(5'b00110, "j");
        step(1'b0, 1'b0, 5'd0, "j_exec", ev(S_E, 1, JMP | PCW | RDST));
        idle("j_done");

        f_d(5'b00010, "jal");
        step(1'b0, 1'b0, 5'd0, "jal_exec", ev(S_E, 0, JMP | PCW | RDST));
        step(1'b0, 1'b0, 5'd0, "jal_wb", ev(S_W, 0, RDST | RWR));
        idle("jal_done");

        f_d(5'b01010, "jr");
        step(1'b0, 1'b0, 5'd0, "jr_exec", ev(S_E, 2, JR | PCW | RDST));
        idle("jr_done");

        f_d(5'b10110, "syscall");
        step(1'b0, 1'b0, 5'd0, "syscall_exec", ev(S_E, 5, CAL));
        idle("syscall_done");

        f_d(5'b10101, "lui");
        step(1'b0, 1'b0, 5'd0, "lui_exec", ev(S_E, 5, SHF | ASRC));
        step(1'b0, 1'b0, 5'd0, "lui_wb", ev(S_W, 5, SHF | ASRC | RWR));
        idle("lui_done");

        f_d(5'b11000, "alu18");
        step(1'b0, 1'b0, 5'd0, "alu18_exec", ev(S_E, 6, RDST));
        step(1'b0, 1'b0, 5'd0, "alu18_wb", ev(S_W, 6, RDST | RWR));
        f_d(5'b10011, "alu19");
        step(1'b0, 1'b0, 5'd0, "alu19_exec", ev(S_E, 4, ASRC));
        step(1'b0, 1'b0, 5'd0, "alu19_wb", ev(S_W, 4, ASRC | RWR));
        idle("alu_done");

        f_d(5'b01001, "lw");
        step(1'b0, 1'b0, 5'd0, "lw_exec", ev(S_E, 0, ASRC));
        step(1'b0, 1'b0, 5'd0, "lw_mem", ev(S_M, 0, ASRC | MRD));
        step(1'b0, 1'b0, 5'd0, "lw_wb", ev(S_W, 0, ASRC | RWR));
        idle("lw_done");

        f_d(5'b00001, "sw");
        step(1'b0, 1'b0, 5'd0, "sw_exec", ev(S_E, 0, ASRC));
        step(1'b0, 1'b0, 5'd0, "sw_mem", ev(S_M, 0, ASRC | MWR));
        idle("sw_done");

`ifdef MCU_MEM_HANDSHAKE_EN
        f_d(5'b01001, "lw_wait");
        step(1'b0, 1'b0, 5'd0, "lw_wait_exec", ev(S_E, 0, ASRC));
        mr_drv = 1'b0;
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 5'd0, "lw_wait_mem", ev(S_M, 0, ASRC | MRD));
        mr_drv = 1'b1;
        step(1'b0, 1'b0, 5'd0, "lw_wait_mem_last", ev(S_M, 0, ASRC | MRD));
        step(1'b0, 1'b0, 5'd0, "lw_wait_wb", ev(S_W, 0, ASRC | RWR));
        idle("lw_wait_done");
`endif

        f_d(5'b01001, "lw_rst");
        step(1'b0, 1'b0, 5'd0, "lw_rst_exec", ev(S_E, 0, ASRC));
        step(1'b1, 1'b0, 5'd0, "lw_rst_in_mem", ev(0, 0, 0));
        idle("lw_rst_fetch0");
        idle("lw_rst_fetch1");

        f_d(5'b11111, "exit");
        step(1'b0, 1'b0, 5'd0, "exit_halt", ev(S_H, 0, HLT));
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'b00000, "halt_ignores_valid", ev(S_H, 0, HLT));
        step(1'b1, 1'b0, 5'd0, "halt_reset", ev(0, 0, 0));
        idle("halt_exit_fetch");

`ifdef MCU_MEM_HANDSHAKE_EN
        f_d(5'b00001, "sw_tmo");
        step(1'b0, 1'b0, 5'd0, "sw_tmo_exec", ev(S_E, 0, ASRC));
        mr_drv = 1'b0;
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b0, 5'd0, "sw_tmo_mem", ev(S_M, 0, ASRC | MWR));
        step(1'b0, 1'b0, 5'd0, "sw_tmo_pulse", ev(S_H, 0, HLT | MTO));
        step(1'b0, 1'b0, 5'd0, "sw_tmo_halt", ev(S_H, 0, HLT));
        mr_drv = 1'b1;
        step(1'b1, 1'b0, 5'd0, "sw_tmo_reset", ev(0, 0, 0));
        idle("sw_tmo_fetch");
`endif

        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
